uart_parity_check_param: RTL and testbench

Parametrised next-generation parity checker for the UART RX path. It tracks a whole frame using an explicit state machine, with:
- runtime-selectable data length (5..DATA_WIDTH bits);
- four parity modes: even, odd, mark, space;
- a one-cycle result strobe;
- a sticky error flag and a saturating error counter.

It sits between the data sampler (sampled_data / sampled_data_valid) and the RX FSM / status registers.

---
 rtl/uart_parity_check_param.sv | 120 ++++++++++++
 tb/tb_uart_parity_check_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_check_param.sv
// rtl/uart_parity_check_param.sv - frame-tracking UART RX parity checker with selectable length/mode and error statistics
module uart_parity_check_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     asy_reset,
    input  logic                     clk_based_on_prescale,
    input  logic                     par_en,
    input  logic [1:0]               par_mode,
    input  logic [3:0]               data_len,
    input  logic                     frame_start,
    input  logic                     sampled_data,
    input  logic                     sampled_data_valid,
    input  logic                     err_clr,
    output logic                     parity_valid,
    output logic                     parity_error,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    localparam logic [3:0]               DW      = 4'(DATA_WIDTH);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

    state_t     state;
    logic [3:0] bit_cnt;
    logic [3:0] len_q;
    logic [1:0] mode_q;
    logic       acc;
    logic [3:0] len_eff;
    logic       exp_par;
    logic       par_bit_seen;
    logic       err_event;

    always_comb begin
        len_eff = data_len;
        if (data_len < 4'd5 || data_len > DW)
            len_eff = DW;
    end

    always_comb begin
        exp_par = 1'b0;
        case (mode_q)
            2'b00:   exp_par = acc;
            2'b01:   exp_par = ~acc;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    // A new frame_start or par_en drop wins over a parity bit arriving in the same cycle.
    assign par_bit_seen = (state == PARITY) && par_en && !frame_start && sampled_data_valid;
    assign err_event    = par_bit_seen && (sampled_data != exp_par);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            len_q        <= 4'd0;
            mode_q       <= 2'b00;
            acc          <= 1'b0;
            parity_valid <= 1'b0;
            parity_error <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
        end else begin
            parity_valid <= 1'b0;

            if (err_event) begin
                err_sticky <= 1'b1;
                if (err_clr)
                    err_count <= ERR_CNT_WIDTH'(1);
                else if (err_count != CNT_MAX)
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
            end else if (err_clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end

            if (!par_en) begin
                state        <= IDLE;
                bit_cnt      <= 4'd0;
                acc          <= 1'b0;
                parity_error <= 1'b0;
            end else if (frame_start) begin
                mode_q       <= par_mode;
                len_q        <= len_eff;
                parity_error <= 1'b0;
                state        <= DATA;
                bit_cnt      <= sampled_data_valid ? 4'd1 : 4'd0;
                acc          <= sampled_data_valid & sampled_data;
            end else begin
                case (state)
                    DATA: begin
                        if (sampled_data_valid) begin
                            acc     <= acc ^ sampled_data;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == len_q - 4'd1)
                                state <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (sampled_data_valid) begin
                            parity_valid <= 1'b1;
                            parity_error <= err_event;
                            state        <= IDLE;
                            bit_cnt      <= 4'd0;
                            acc          <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_parity_check_param.sv
// tb/tb_uart_parity_check_param.sv - scoreboard bench for uart_parity_check_param
module tb_uart_parity_check_param;

    logic       asy_reset;
    logic       clk_based_on_prescale;
    logic       par_en;
    logic [1:0] par_mode;
    logic [3:0] data_len;
    logic       frame_start;
    logic       sampled_data;
    logic       sampled_data_valid;
    logic       err_clr;
    logic       parity_valid;
    logic       parity_error;
    logic       err_sticky;
    logic [1:0] err_count;
    logic       busy;

    uart_parity_check_param #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) dut (
        .asy_reset             (asy_reset),
        .clk_based_on_prescale (clk_based_on_prescale),
        .par_en                (par_en),
        .par_mode              (par_mode),
        .data_len              (data_len),
        .frame_start           (frame_start),
        .sampled_data          (sampled_data),
        .sampled_data_valid    (sampled_data_valid),
        .err_clr               (err_clr),
        .parity_valid          (parity_valid),
        .parity_error          (parity_error),
        .err_sticky            (err_sticky),
        .err_count             (err_count),
        .busy                  (busy)
    );

    initial clk_based_on_prescale = 1'b0;
    always #5 clk_based_on_prescale = ~clk_based_on_prescale;

    typedef struct {
        logic       err;
        logic [1:0] cnt;
        logic       sticky;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         pushes = 0;
    logic [1:0] m_cnt = 2'd0;
    logic       m_sticky = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_based_on_prescale) begin
        if (parity_valid === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("parity_error", parity_error, e.err);
                check("err_count", err_count, e.cnt);
                check("err_sticky", err_sticky, e.sticky);
            end
        end
    end

    task automatic tick();
        @(posedge clk_based_on_prescale);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int gap);
        sampled_data = b;
        sampled_data_valid = 1'b1;
        tick();
        sampled_data_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_frame(input logic [1:0] mode, input logic [3:0] len);
        frame_start = 1'b1;
        par_mode = mode;
        data_len = len;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] mode, input logic [3:0] len, input logic [8:0] data,
                              input logic pbit, input int gap, input logic clr);
        int   n;
        logic x;
        logic exp_p;
        logic err;
        exp_t e;
        n = (len < 5 || len > 8) ? 8 : int'(len);
        x = 1'b0;
        for (int i = 0; i < n; i++) x ^= data[i];
        case (mode)
            2'b00:   exp_p = x;
            2'b01:   exp_p = ~x;
            2'b10:   exp_p = 1'b1;
            default: exp_p = 1'b0;
        endcase
        err = (pbit != exp_p);
        start_frame(mode, len);
        for (int i = 0; i < n; i++) drive_bit(data[i], gap);
        check("busy_at_parity", busy, 1'b1);
        if (err) begin
            m_sticky = 1'b1;
            m_cnt = clr ? 2'd1 : ((m_cnt == 2'd3) ? 2'd3 : m_cnt + 2'd1);
        end else if (clr) begin
            m_sticky = 1'b0;
            m_cnt = 2'd0;
        end
        e.err = err;
        e.cnt = m_cnt;
        e.sticky = m_sticky;
        sb_q.push_back(e);
        pushes++;
        err_clr = clr;
        sampled_data = pbit;
        sampled_data_valid = 1'b1;
        tick();
        sampled_data_valid = 1'b0;
        err_clr = 1'b0;
        check("pv_latency", parity_valid, 1'b1);
        tick();
        check("pv_one_cycle", parity_valid, 1'b0);
        check("busy_after", busy, 1'b0);
    endtask

    initial begin
        asy_reset = 1'b0;
        par_en = 1'b1;
        par_mode = 2'b00;
        data_len = 4'd8;
        frame_start = 1'b0;
        sampled_data = 1'b0;
        sampled_data_valid = 1'b0;
        err_clr = 1'b0;
        #3;
        check("rst_pv", parity_valid, 1'b0);
        check("rst_pe", parity_error, 1'b0);
        check("rst_sticky", err_sticky, 1'b0);
        check("rst_cnt", err_count, 2'd0);
        check("rst_busy", busy, 1'b0);
        tick();
        asy_reset = 1'b1;
        tick();

        // even/odd basics
        send_frame(2'b00, 4'd8, 9'b0_1011_0010, 1'b0, 0, 1'b0);
        send_frame(2'b01, 4'd7, 9'b00_110_0001, 1'b1, 0, 1'b0);
        send_frame(2'b01, 4'd7, 9'b00_110_0001, 1'b0, 0, 1'b0);
        check("sticky_held", err_sticky, 1'b1);

        // mark, space, out-of-range length clamps to 8
        send_frame(2'b10, 4'd5, 9'b0_0001_0101, 1'b0, 0, 1'b0);
        send_frame(2'b11, 4'd5, 9'b0_0001_0101, 1'b0, 0, 1'b0);
        send_frame(2'b00, 4'd12, 9'b0_1110_0110, 1'b1, 0, 1'b0);
        send_frame(2'b01, 4'd3, 9'b0_0000_0001, 1'b0, 1, 1'b0);

        // idle-state valids ignored, then abort mid-frame and restart
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 0);
        check("idle_busy", busy, 1'b0);
        start_frame(2'b00, 4'd8);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 0);
        send_frame(2'b00, 4'd8, 9'b0_1100_1010, 1'b0, 0, 1'b0);
        send_frame(2'b00, 4'd8, 9'b0_0111_0101, 1'b1, 3, 1'b0);

        // clear, saturation, clear coinciding with an error
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_cnt = 2'd0;
        m_sticky = 1'b0;
        check("clr_cnt", err_count, 2'd0);
        check("clr_sticky", err_sticky, 1'b0);
        for (int i = 0; i < 5; i++)
            send_frame(2'b10, 4'd5, 9'b0_0000_0110, 1'b0, 0, 1'b0);
        check("sat_cnt", err_count, 2'd3);
        send_frame(2'b10, 4'd5, 9'b0_0000_0110, 1'b0, 0, 1'b1);

        // par_en drop mid-frame, with an ignored frame_start
        start_frame(2'b00, 4'd8);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 0);
        par_en = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("pe_off_busy", busy, 1'b0);
        check("pe_off_perr", parity_error, 1'b0);
        check("pe_off_cnt", err_count, m_cnt);
        check("pe_off_sticky", err_sticky, m_sticky);
        par_en = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(1'b1, 0);
        check("pe_on_busy", busy, 1'b0);

        // asynchronous reset mid-frame after an error frame
        send_frame(2'b11, 4'd6, 9'b0_0010_1101, 1'b1, 0, 1'b0);
        start_frame(2'b00, 4'd8);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 0);
        #2;
        asy_reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_perr", parity_error, 1'b0);
        check("arst_cnt", err_count, 2'd0);
        check("arst_sticky", err_sticky, 1'b0);
        m_cnt = 2'd0;
        m_sticky = 1'b0;
        tick();
        asy_reset = 1'b1;
        for (int i = 0; i < 6; i++) drive_bit(1'b1, 0);
        check("post_rst_busy", busy, 1'b0);

        repeat (4) tick();
        check("sb_empty", sb_q.size(), 32'd0);
        check("pulse_count", pulses, pushes);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
